// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the execute stage and the iterative multiply/divide unit.
// The master drives the request; the slave returns status and the HI/LO registers.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, x, y,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, x, y,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle,
// followed by a single sign-fixup cycle that writes the architectural HI/LO registers.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  muldiv_unit_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              is_div_q, is_div_d;
  logic              neg_q, neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic              div_zero_q, div_zero_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  logic              x_neg, y_neg;
  logic [WIDTH-1:0]  x_mag, y_mag;
  logic [WIDTH:0]    rem_sh;
  logic [WIDTH-1:0]  rem_low;
  logic              rem_ge;
  logic [WIDTH:0]    mul_sum;
  logic [2*WIDTH-1:0] prod, prod_neg;

  always_comb begin
    // op[0] set means unsigned for the four iterative ops
    x_neg   = bus.x[WIDTH-1] & ~bus.op[0];
    y_neg   = bus.y[WIDTH-1] & ~bus.op[0];
    x_mag   = x_neg ? -bus.x : bus.x;
    y_mag   = y_neg ? -bus.y : bus.y;

    // Restoring step: the true difference always fits WIDTH bits when rem_ge is set
    rem_sh  = {acc_q, q_q[WIDTH-1]};
    rem_ge  = rem_sh >= {1'b0, b_q};
    rem_low = rem_sh[WIDTH-1:0];

    mul_sum  = {1'b0, acc_q} + ({1'b0, b_q} & {(WIDTH+1){q_q[0]}});
    prod     = {acc_q, q_q};
    prod_neg = -prod;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    q_d        = q_q;
    b_d        = b_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (!bus.op[2]) begin
            state_d    = StCalc;
            cnt_d      = '0;
            acc_d      = '0;
            is_div_d   = bus.op[1];
            neg_d      = x_neg ^ y_neg;
            rem_neg_d  = x_neg;
            div_zero_d = (bus.y == '0);
            // Divide shifts the dividend out of q; multiply shifts the multiplier out of q
            q_d        = bus.op[1] ? x_mag : y_mag;
            b_d        = bus.op[1] ? y_mag : x_mag;
          end else if (!bus.op[1]) begin
            if (bus.op[0]) lo_d = bus.x;
            else           hi_d = bus.x;
          end
        end
      end
      StCalc: begin
        if (is_div_q) begin
          acc_d = rem_ge ? (rem_low - b_q) : rem_low;
          q_d   = {q_q[WIDTH-2:0], rem_ge};
        end else begin
          {acc_d, q_d} = {mul_sum, q_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        if (is_div_q) begin
          // A zero divisor leaves rem = |x|, so the remainder fixup already restores x
          lo_d = div_zero_q ? '1 : (neg_q ? -q_q : q_q);
          hi_d = rem_neg_q ? -acc_q : acc_q;
        end else begin
          {hi_d, lo_d} = neg_q ? prod_neg : prod;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      q_q        <= '0;
      b_q        <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      q_q        <= q_d;
      b_q        <= b_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed HI/LO results.
module tb_muldiv_unit;

  localparam int unsigned WIDTH = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_bad;

  muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle start pulse; returns #1 after the sampling edge
  task automatic pulse(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.x     = a;
    bus.y     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.x     = 32'h5A5A_0F0F;
    bus.y     = 32'h0000_0003;
  endtask

  // Issues an iterative op and watches 40 cycles, counting busy/done and capturing HI/LO at done
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cnt, output int done_cnt,
                        output logic [31:0] hi_v, output logic [31:0] lo_v);
    pulse(o, a, b);
    busy_cnt = 0;
    done_cnt = 0;
    hi_v     = 32'hxxxx_xxxx;
    lo_v     = 32'hxxxx_xxxx;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        hi_v = bus.hi;
        lo_v = bus.lo;
      end
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          bc, dc;
    logic [31:0] hv, lv;
    int          seen;

    n_checks  = 0;
    n_bad     = 0;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.x     = '0;
    bus.y     = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("reset_done", {63'd0, bus.done}, 64'd0);
    check_eq("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // MTHI / MTLO are single-cycle and never raise busy or done
    pulse(3'b100, 32'hA5A5_A5A5, 32'h0);
    check_eq("mthi_hi", {32'd0, bus.hi}, 64'hA5A5_A5A5);
    check_eq("mthi_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    pulse(3'b101, 32'h1357_9BDF, 32'h0);
    check_eq("mtlo_lo", {bus.hi, bus.lo}, 64'hA5A5_A5A5_1357_9BDF);
    check_eq("mtlo_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    pulse(3'b110, 32'hFFFF_FFFF, 32'h1);
    check_eq("reserved_noop", {bus.hi, bus.lo}, 64'hA5A5_A5A5_1357_9BDF);
    check_eq("reserved_busy", {63'd0, bus.busy}, 64'd0);

    // Reset during the 10th CALC cycle abandons the operation
    pulse(3'b001, 32'd5, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    check_eq("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen++;
    end
    check_eq("midrst_no_done", 64'(seen), 64'd0);

    vecs[0] = '{"multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{"mult_m1m1", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[2] = '{"mult_m3x7", 3'b000, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[3] = '{"div_m7d2",  3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{"divu_100",  3'b011, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[5] = '{"divu_zero", 3'b011, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF};
    vecs[6] = '{"div_ovf",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[7] = '{"div_negz",  3'b010, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].x, vecs[i].y, bc, dc, hv, lv);
      check_eq({vecs[i].name, "_busy_cycles"}, 64'(bc), 64'd33);
      check_eq({vecs[i].name, "_done_cycles"}, 64'(dc), 64'd1);
      check_eq({vecs[i].name, "_hilo"}, {hv, lv}, {vecs[i].hi, vecs[i].lo});
    end

    // Starts issued while busy are dropped, not queued
    pulse(3'b011, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    pulse(3'b101, 32'hDEAD_BEEF, 32'h0);
    repeat (2) @(posedge clk);
    pulse(3'b000, 32'd3, 32'd3);
    seen = 0;
    for (int i = 0; i < 40 && !bus.done; i++) begin
      @(posedge clk);
      #1;
      seen++;
    end
    check_eq("busy_ign_done", {63'd0, bus.done}, 64'd1);
    check_eq("busy_ign_hilo", {bus.hi, bus.lo}, {32'd2, 32'd14});
    repeat (2) @(posedge clk);
    #1;
    check_eq("busy_ign_no_queue", {62'd0, bus.busy, bus.done}, 64'd0);
    check_eq("busy_ign_hold", {bus.hi, bus.lo}, {32'd2, 32'd14});

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the MIPS execute stage, beside the combinational ALU.
- Takes the same register-file operands x and y as the ALU.
- Performs MULT, MULTU, DIV and DIVU over multiple cycles, and MTHI/MTLO in one cycle.
- Holds the architectural HI/LO registers that MFHI/MFLO read in writeback.
- Pipeline control stalls on busy.

Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is verified.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (no-op).
- x  input  WIDTH  operand A: multiplicand, dividend, or MTHI/MTLO source.
- y  input  WIDTH  operand B: multiplier or divisor.
- busy  output  1  high while an iterative operation is in progress.
- done  output  1  one-cycle pulse after HI/LO are written by MULT/DIV.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: a synchronous rst at any clock edge, including mid-operation, forces:
  - state=IDLE, busy=0, done=0, hi=0, lo=0;
  - iteration counter and internal accumulators cleared;
  - any in-flight operation abandoned with no HI/LO write.
- States and transitions:
  - IDLE: start=1 with op 000–011 latches x, y, op and signedness, goes to CALC, counter=0. start=1 with op 100 writes hi<=x at that edge and stays IDLE. start=1 with op 101 writes lo<=x likewise. MTHI/MTLO never assert busy or done. Reserved ops are ignored.
  - CALC: exactly 32 cycles, one bit per cycle. Counter increments 0..31; at 31 go to FIX.
  - FIX: one cycle. Applies signed correction and writes hi/lo at the end of this cycle, then goes to IDLE.
- busy: 1 in CALC and FIX (33 cycles), 0 otherwise. It is registered, so it rises the cycle after the start edge.
- done: 1 for exactly the first IDLE cycle after FIX; 0 otherwise.
- Latency: start sampled at edge E0; hi/lo new and done=1 after edge E0+33; the next start can be accepted at edge E0+34 (that cycle's IDLE).
- start while busy: ignored entirely; no queueing. Operand changes on x/y during CALC/FIX have no effect.
- Multiply: shift-add on operand magnitudes; 64-bit product with {hi,lo}=product.
  - MULTU: unsigned.
  - MULT: two's-complement; product negated in FIX when sign(x)^sign(y).
- Divide: restoring division on magnitudes; lo=quotient, hi=remainder.
  - DIVU: unsigned.
  - DIV: quotient negated if sign(x)^sign(y); remainder takes sign of dividend (truncation toward zero).
  - 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0.
- Divide by zero (y=0), DIV or DIVU: full latency is still taken, then lo=0xFFFFFFFF and hi=x (original, unsigned bit pattern). There is no exception.
- hi/lo change only on: reset, MTHI/MTLO in IDLE, or the end of FIX.

Test Plan:
- Reset mid-operation: MULTU 5×7, assert rst at the 10th CALC cycle -> next cycle busy=0, done=0, hi=0, lo=0; no done pulse follows.
- MULTU x=0xFFFFFFFF, y=0xFFFFFFFF -> after 33 busy cycles, done pulse with hi=0xFFFFFFFE, lo=0x00000001. MULT on the same operands -> hi=0, lo=1.
- MULT x=0xFFFFFFFD (-3), y=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Check busy is high for exactly 33 cycles and done for exactly 1.
- DIV x=0xFFFFFFF9 (-7), y=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU x=100, y=7 -> lo=14, hi=2.
- DIVU x=0x12345678, y=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Handshake:
  - MTHI x=0xA5A5A5A5 in IDLE -> hi updated next cycle; busy and done stay 0.
  - Issue DIVU, then start MTLO and MULT while busy -> both ignored; lo reflects only the DIVU result.
